// File: rtl/nibble_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_adder_pkg
// Description : Shared definitions for the nibble-serial adder: nibble width,
//               controller state encoding and a nibble-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_adder_pkg;

  // Width of one carry-look-ahead stage; every operand is processed in
  // slices of this many bits.
  localparam int NIBBLE_W = 4;

  // Controller states, explicitly encoded so the register width is fixed.
  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_RUN  = 2'd1;
  localparam logic [1:0] C_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = C_ST_IDLE,
    RUN  = C_ST_RUN,
    DONE = C_ST_DONE
  } state_e;

  // Number of nibble slices in an operand of the given width.
  function automatic int num_nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage : nibble_adder_pkg
`default_nettype wire

// File: rtl/carry_look_ahead_adder.sv
`default_nettype none
// ============================================================================
// Module      : carry_look_ahead_adder
// Description : 4-bit carry-look-ahead adder stage. All internal carries and
//               the carry-out are formed directly from generate/propagate
//               terms, so there is no ripple path through the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module carry_look_ahead_adder
  import nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_cout
);

  logic [NIBBLE_W-1:0] w_g;   // bit generate
  logic [NIBBLE_W-1:0] w_p;   // bit propagate
  logic [NIBBLE_W-1:0] w_c;   // carry into each bit position

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Look-ahead carry equations, fully expanded per bit position.
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign o_cout = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  // Each sum bit is its propagate term XOR the carry into that position.
  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_sum
    assign o_sum[gi] = w_p[gi] ^ w_c[gi];
  end

endmodule : carry_look_ahead_adder
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : Serial adder/subtractor. An accepted operand pair is summed
//               one nibble per clock through a single shared 4-bit
//               carry-look-ahead stage; the result, carry-out and signed
//               overflow are then held until the downstream takes them.
//               WIDTH must be a multiple of 4 between 8 and 64.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = num_nibbles(WIDTH);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] C_K_LAST = KW'(N - 1);

  state_e              r_state;
  logic [WIDTH-1:0]    r_a_sh;      // operand A, shifted down one nibble per RUN cycle
  logic [WIDTH-1:0]    r_b_sh;      // effective operand B, shifted likewise
  logic                r_a_msb;     // sign of A, kept for the overflow flag
  logic                r_b_msb;     // sign of effective B, kept for the overflow flag
  logic                r_carry;     // carry between nibble slices
  logic [KW-1:0]       r_k;         // index of the nibble being processed

  logic                w_accept;
  logic                w_deliver;
  logic                w_run;
  logic                w_last;
  logic [WIDTH-1:0]    w_b_eff;
  logic                w_c0;
  logic [NIBBLE_W-1:0] w_nib_sum;
  logic                w_nib_cout;

  // Subtraction is A + ~B + 1, so only the operand and initial carry differ.
  assign w_b_eff   = sub ? ~b : b;
  assign w_c0      = sub ? 1'b1 : cin;

  // in_ready is gated by rst_n so that nothing is offered while held in reset.
  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);

  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;
  assign w_run     = (r_state == RUN);
  assign w_last    = w_run && (r_k == C_K_LAST);

  // The low nibble of each shift register is always the slice for index k.
  carry_look_ahead_adder u_cla (
    .i_a    (r_a_sh[NIBBLE_W-1:0]),
    .i_b    (r_b_sh[NIBBLE_W-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_nib_sum),
    .o_cout (w_nib_cout)
  );

  // Controller: IDLE -> RUN on acceptance, RUN -> DONE after the last nibble,
  // DONE -> IDLE once the result has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept)  r_state <= RUN;
        RUN:     if (w_last)    r_state <= DONE;
        DONE:    if (w_deliver) r_state <= IDLE;
        default:                r_state <= IDLE;
      endcase
    end
  end

  // Operand capture on acceptance, then one nibble shift and carry update per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_carry <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= w_b_eff;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= w_b_eff[WIDTH-1];
      r_carry <= w_c0;
      r_k     <= '0;
    end else if (w_run) begin
      r_a_sh  <= {{NIBBLE_W{1'b0}}, r_a_sh[WIDTH-1:NIBBLE_W]};
      r_b_sh  <= {{NIBBLE_W{1'b0}}, r_b_sh[WIDTH-1:NIBBLE_W]};
      r_carry <= w_nib_cout;
      r_k     <= r_k + 1'b1;
    end
  end

  // Result slices are written in place; the flags are taken from the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (w_run) begin
      sum[{r_k, 2'b00} +: NIBBLE_W] <= w_nib_sum;
      if (w_last) begin
        cout <= w_nib_cout;
        ovf  <= (r_a_msb == r_b_msb) && (w_nib_sum[NIBBLE_W-1] != r_a_msb);
      end
    end
  end

endmodule : nibble_serial_adder
`default_nettype wire

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits; legal values are multiples of 4 from 8 to 64.
REQ-002 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be an asynchronous active-low reset.
REQ-004 Port in_valid, input, 1, SHALL mean the upstream offers an operand pair.
REQ-005 Port in_ready, output, 1, SHALL mean the block accepts an operand pair this cycle.
REQ-006 Port a, input, WIDTH, SHALL be operand A.
REQ-007 Port b, input, WIDTH, SHALL be operand B.
REQ-008 Port cin, input, 1, SHALL be the carry-in for add mode.
REQ-009 Port sub, input, 1, SHALL select A-B when 1 and A+B+cin when 0.
REQ-010 Port out_valid, output, 1, SHALL mean the result is valid.
REQ-011 Port out_ready, input, 1, SHALL mean the downstream accepts the result.
REQ-012 Port sum, output, WIDTH, SHALL carry the result bits.
REQ-013 Port cout, output, 1, SHALL carry the final carry-out; in sub mode cout=1 means no borrow.
REQ-014 Port ovf, output, 1, SHALL be the two's-complement signed overflow flag.
REQ-015 Port busy, output, 1, SHALL be high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; in_valid is ignored in RUN and DONE.
REQ-018 Transition IDLE->RUN on in_valid&&in_ready: register a, b_eff, c0 and the nibble index k=0.
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
REQ-019 In RUN, each cycle SHALL add nibble k of A and b_eff with the carry register through one 4-bit carry-look-ahead stage.
  - Write the 4 sum bits into sum[4k+3:4k].
  - Load the stage carry-out into the carry register.
  - Increment k.
REQ-020 RUN SHALL last exactly N=WIDTH/4 cycles; after the edge that processes k=N-1, the state SHALL be DONE.
REQ-021 Latency: with acceptance at edge t, out_valid SHALL be 1 after edge t+N.
REQ-022 In DONE, out_valid=1; sum, cout and ovf SHALL hold stable until out_valid&&out_ready; on that edge the state SHALL return to IDLE.
REQ-023 Throughput SHALL be at most one operation per N+2 cycles; acceptance and result delivery SHALL NOT overlap.
REQ-024 cout SHALL equal the carry out of nibble N-1.
REQ-025 ovf SHALL equal (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]).
REQ-026 The result SHALL wrap modulo 2^WIDTH.
REQ-027 When out_valid=0, sum, cout and ovf SHALL retain their last values; downstream SHALL NOT sample them.

Reset
REQ-028 On rst_n low, the block SHALL immediately enter IDLE and clear all of the following to 0:
  - sum, cout, ovf, out_valid, busy;
  - the carry register and k.
  in_ready SHALL be 1 while rst_n is high in IDLE and 0 while rst_n is low.
REQ-029 Reset during RUN or DONE SHALL discard the operation with no partial result delivered; the first cycle after release SHALL accept new operands.

Structure
REQ-030 The shared package nibble_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the constant NIBBLE_W=4.
REQ-031 The block SHALL instantiate exactly one sub-module, the team's existing 4-bit carry-look-ahead adder stage carry_look_ahead_adder, reused for every nibble.
REQ-032 The block SHALL contain no other adders on the datapath.

Verification (WIDTH=16)
REQ-033 Add: a=16'h1234, b=16'h4321, cin=0, sub=0 -> out_valid exactly 4 cycles after acceptance, sum=16'h5555, cout=0, ovf=0.
REQ-034 Ripple wrap: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0.
REQ-035 Subtract: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0.
  - Signed overflow: a=16'h7FFF, b=16'h0001, add -> sum=16'h8000, ovf=1.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum stable and in_ready=0 throughout; in_ready returns to 1 the cycle after out_ready=1.
REQ-037 Reset mid-operation: assert rst_n=0 at RUN cycle 2 -> out_valid and busy drop immediately, no result delivered; the next accepted operation produces a correct sum.
